cdb_arbiter: RTL and testbench

//   Common data bus arbiter between the execution units and the CDB consumers.

---
 rtl/cdb_arbiter.sv | 120 ++++++++++++
 tb/tb_cdb_arbiter.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: buffers ALU and MEM results in small per-source FIFOs
// and broadcasts one result per cycle, round-robin, on a registered bus.
module cdb_arbiter #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 23
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             alu_done,
  input  logic [WIDTH-1:0] alu_solution,
  input  logic             mem_done,
  input  logic [WIDTH-1:0] mem_solution,
  output logic             alu_full,
  output logic             mem_full,
  output logic             cdb_valid,
  output logic [WIDTH-1:0] cdb_data,
  output logic             cdb_src,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  // Index 0 is the ALU source, index 1 the MEM source.
  logic [1:0]       push;
  logic [1:0]       pop;
  logic [1:0]       non_empty;
  logic [1:0]       full;
  logic [WIDTH-1:0] din  [2];
  logic [WIDTH-1:0] head [2];

  logic             grant_mem;
  logic             grant_any;

  logic             prio_reg;
  logic             cdb_valid_reg;
  logic [WIDTH-1:0] cdb_data_reg;
  logic             cdb_src_reg;
  logic             overflow_reg;

  assign push    = {mem_done, alu_done};
  assign din[0]  = alu_solution;
  assign din[1]  = mem_solution;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
      logic [WIDTH-1:0] mem_q [DEPTH];
      logic [PTR_W-1:0] wr_ptr_reg;
      logic [PTR_W-1:0] rd_ptr_reg;
      logic [CNT_W-1:0] count_reg;
      logic             accept;

      assign full[gi]      = (count_reg == CNT_W'(DEPTH));
      assign non_empty[gi] = (count_reg != '0);
      // A strobe into a full FIFO still lands if the head leaves on the same edge.
      assign accept        = push[gi] && (!full[gi] || pop[gi]);
      assign head[gi]      = mem_q[rd_ptr_reg];

      always_ff @(posedge clock) begin
        if (reset) begin
          wr_ptr_reg <= '0;
          rd_ptr_reg <= '0;
          count_reg  <= '0;
        end else begin
          if (accept) begin
            wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
          end
          if (pop[gi]) begin
            rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
          end
          case ({accept, pop[gi]})
            2'b10:   count_reg <= count_reg + CNT_W'(1);
            2'b01:   count_reg <= count_reg - CNT_W'(1);
            default: count_reg <= count_reg;
          endcase
        end
      end

      always_ff @(posedge clock) begin
        if (accept) begin
          mem_q[wr_ptr_reg] <= din[gi];
        end
      end
    end
  endgenerate

  // MEM wins when it is the only candidate or holds priority over a busy ALU.
  assign grant_mem = non_empty[1] && (!non_empty[0] || prio_reg);
  assign grant_any = |non_empty;
  assign pop[0]    = non_empty[0] && !grant_mem;
  assign pop[1]    = grant_mem;

  always_ff @(posedge clock) begin
    if (reset) begin
      prio_reg      <= 1'b0;
      cdb_valid_reg <= 1'b0;
      cdb_data_reg  <= '0;
      cdb_src_reg   <= 1'b0;
      overflow_reg  <= 1'b0;
    end else begin
      cdb_valid_reg <= grant_any;
      if (grant_any) begin
        cdb_data_reg <= grant_mem ? head[1] : head[0];
        cdb_src_reg  <= grant_mem;
        prio_reg     <= !grant_mem;
      end
      if (|(push & full & ~pop)) begin
        overflow_reg <= 1'b1;
      end
    end
  end

  assign alu_full  = full[0];
  assign mem_full  = full[1];
  assign cdb_valid = cdb_valid_reg;
  assign cdb_data  = cdb_data_reg;
  assign cdb_src   = cdb_src_reg;
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed, table-driven bench for cdb_arbiter: each row is driven for one edge
// and all outputs are compared 1 time unit after that edge.
module tb_cdb_arbiter;

  logic        clock;
  logic        reset;
  logic        alu_done;
  logic [22:0] alu_solution;
  logic        mem_done;
  logic [22:0] mem_solution;
  logic        alu_full;
  logic        mem_full;
  logic        cdb_valid;
  logic [22:0] cdb_data;
  logic        cdb_src;
  logic        overflow;

  int checks = 0;
  int errors = 0;

  cdb_arbiter #(.DEPTH(2), .WIDTH(23)) dut (
    .clock        (clock),
    .reset        (reset),
    .alu_done     (alu_done),
    .alu_solution (alu_solution),
    .mem_done     (mem_done),
    .mem_solution (mem_solution),
    .alu_full     (alu_full),
    .mem_full     (mem_full),
    .cdb_valid    (cdb_valid),
    .cdb_data     (cdb_data),
    .cdb_src      (cdb_src),
    .overflow     (overflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        rst;
    logic        a_d;
    logic [22:0] a_s;
    logic        m_d;
    logic [22:0] m_s;
    logic        e_valid;
    logic [22:0] e_data;
    logic        e_src;
    logic        e_af;
    logic        e_mf;
    logic        e_ov;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic rst, input logic a_d, input logic [22:0] a_s,
                              input logic m_d, input logic [22:0] m_s,
                              input logic v, input logic [22:0] d, input logic s,
                              input logic af, input logic mf, input logic ov);
    vec_t r;
    r.rst = rst; r.a_d = a_d; r.a_s = a_s; r.m_d = m_d; r.m_s = m_s;
    r.e_valid = v; r.e_data = d; r.e_src = s; r.e_af = af; r.e_mf = mf; r.e_ov = ov;
    return r;
  endfunction

  task automatic check(input string tag, input logic [22:0] got, input logic [22:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    reset        = v.rst;
    alu_done     = v.a_d;
    alu_solution = v.a_s;
    mem_done     = v.m_d;
    mem_solution = v.m_s;
    @(posedge clock);
    #1;
    $display("row %0d: rst=%0d alu=%0d:%06h mem=%0d:%06h -> valid=%0d data=%06h src=%0d af=%0d mf=%0d ov=%0d",
             idx, v.rst, v.a_d, v.a_s, v.m_d, v.m_s, cdb_valid, cdb_data, cdb_src,
             alu_full, mem_full, overflow);
    check($sformatf("row%0d valid", idx), 23'(cdb_valid), 23'(v.e_valid));
    check($sformatf("row%0d data", idx), cdb_data, v.e_data);
    check($sformatf("row%0d src", idx), 23'(cdb_src), 23'(v.e_src));
    check($sformatf("row%0d alu_full", idx), 23'(alu_full), 23'(v.e_af));
    check($sformatf("row%0d mem_full", idx), 23'(mem_full), 23'(v.e_mf));
    check($sformatf("row%0d overflow", idx), 23'(overflow), 23'(v.e_ov));
  endtask

  // Single strobe from one source into an idle arbiter; expects broadcast one edge later.
  task automatic latency_seq(input logic src, input logic [22:0] val);
    int  lat;
    bit  found;
    reset        = 1'b0;
    alu_done     = !src;
    alu_solution = val;
    mem_done     = src;
    mem_solution = val;
    @(posedge clock);
    #1;
    alu_done = 1'b0;
    mem_done = 1'b0;
    check($sformatf("lat%0d early_valid", src), 23'(cdb_valid), 23'd0);
    found = 0;
    lat   = 0;
    for (int c = 1; c <= 8; c++) begin
      @(posedge clock);
      #1;
      if (cdb_valid) begin
        found = 1;
        lat   = c;
        break;
      end
    end
    $display("latency src=%0d val=%06h -> found=%0d lat=%0d data=%06h src=%0d",
             src, val, found, lat, cdb_data, cdb_src);
    check($sformatf("lat%0d seen", src), 23'(found), 23'd1);
    check($sformatf("lat%0d cycles", src), 23'(lat), 23'd1);
    check($sformatf("lat%0d data", src), cdb_data, val);
    check($sformatf("lat%0d src", src), 23'(cdb_src), 23'(src));
    @(posedge clock);
    #1;
    check($sformatf("lat%0d after_valid", src), 23'(cdb_valid), 23'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    alu_done     = 1'b0;
    alu_solution = '0;
    mem_done     = 1'b0;
    mem_solution = '0;

    // Reset and idle
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 5; i++) vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Single ALU result, latency 1, data held afterwards
    vecs.push_back(mk(0, 1, 23'h201234, 0, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0, 1, 23'h201234, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0, 0, 23'h201234, 0, 0, 0, 0));
    // Simultaneous results after reset: ALU first
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h0A0011, 1, 23'h0B0022, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h0A0011, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h0B0022, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          0, 23'h0B0022, 1, 0, 0, 0));
    // Fairness: both FIFOs kept non-empty, grants alternate
    vecs.push_back(mk(0, 1, 23'h100011, 1, 23'h200021, 0, 23'h0B0022, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h100012, 0, 0,          1, 23'h100011, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          1, 23'h200022, 1, 23'h200021, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h100013, 0, 0,          1, 23'h100012, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          1, 23'h200023, 1, 23'h200022, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h100013, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h200023, 1, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0,          0, 23'h200023, 1, 0, 0, 0));
    // Overflow: MEM fills, a push into full with pop is kept, a push without pop is dropped
    vecs.push_back(mk(0, 1, 23'h300031, 1, 23'h400041, 0, 23'h200023, 1, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h300032, 1, 23'h400042, 1, 23'h300031, 0, 0, 1, 0));
    vecs.push_back(mk(0, 1, 23'h300033, 1, 23'h400043, 1, 23'h400041, 1, 1, 1, 0));
    vecs.push_back(mk(0, 0, 0,          1, 23'h400044, 1, 23'h300032, 0, 0, 1, 1));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h400042, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h300033, 0, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,          0, 0,          1, 23'h400043, 1, 0, 0, 1));
    vecs.push_back(mk(0, 0, 0,          0, 0,          0, 23'h400043, 1, 0, 0, 1));
    // Reset with entries buffered discards them
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h500051, 1, 23'h600061, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 1, 23'h700071, 0, 0, 0, 0,           0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0, 1, 23'h700071, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0,          0, 0, 0, 23'h700071, 0, 0, 0, 0));

    for (int i = 0; i < vecs.size(); i++) begin
      apply(i, vecs[i]);
    end

    latency_seq(1'b0, 23'h012345);
    latency_seq(1'b1, 23'h6ABCDE);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
